// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared AXI4-Lite definitions for the write master. The read side will use
// the same response codes.
//   axi_resp_e  : B/R channel response codes
//   wm_state_e  : write-master control states
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    WM_IDLE   = 2'b00,
    WM_SEND   = 2'b01,
    WM_WAIT_B = 2'b10,
    WM_DONE   = 2'b11
  } wm_state_e;

endpackage : axi4_lite_pkg

// File: rtl/axi4_lite_write_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_write_master
// Takes one store request from the LSU, issues it on the AXI4-Lite AW and W
// channels, waits for the B response, and returns that response to the LSU.
// Only one transaction is in flight at a time.
//
// Ports
//   CLK, RST_N                     clock, asynchronous active-low reset
//   REQ_VALID/READY, REQ_ADDR,
//   REQ_DATA, REQ_STRB             LSU store request (valid/ready)
//   AW_ADDR/VALID/READY            AXI write address channel
//   W_DATA/STRB/VALID/READY        AXI write data channel
//   B_RESP/VALID/READY             AXI write response channel
//   DONE_VALID/READY, DONE_RESP    result back to the LSU (valid/ready)
// -----------------------------------------------------------------------------
module axi4_lite_write_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                CLK,
  input  logic                RST_N,
  // LSU request
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic [ADDR_W-1:0]   REQ_ADDR,
  input  logic [DATA_W-1:0]   REQ_DATA,
  input  logic [DATA_W/8-1:0] REQ_STRB,
  // AXI write address
  output logic [ADDR_W-1:0]   AW_ADDR,
  output logic                AW_VALID,
  input  logic                AW_READY,
  // AXI write data
  output logic [DATA_W-1:0]   W_DATA,
  output logic [DATA_W/8-1:0] W_STRB,
  output logic                W_VALID,
  input  logic                W_READY,
  // AXI write response
  input  logic [1:0]          B_RESP,
  input  logic                B_VALID,
  output logic                B_READY,
  // LSU result
  output logic                DONE_VALID,
  output logic [1:0]          DONE_RESP,
  input  logic                DONE_READY
);

  wm_state_e state;
  logic      aw_done;
  logic      w_done;
  logic      aw_hs;
  logic      w_hs;

  // Handshake strobes: both operands are registered VALIDs and slave READYs,
  // so no READY ever reaches a VALID combinationally.
  assign aw_hs = AW_VALID & AW_READY;
  assign w_hs  = W_VALID & W_READY;

  // Pure decodes of the state register, so no input-to-output path exists.
  assign REQ_READY = (state == WM_IDLE);
  assign B_READY   = (state == WM_WAIT_B);

  // NOTE: every register here is updated with <= so that all reads within a
  // cycle see the pre-edge values; mixing in = would make the result depend on
  // statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= WM_IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      AW_ADDR    <= '0;
      AW_VALID   <= 1'b0;
      W_DATA     <= '0;
      W_STRB     <= '0;
      W_VALID    <= 1'b0;
      DONE_VALID <= 1'b0;
      DONE_RESP  <= RESP_OKAY;
    end else begin
      case (state)
        WM_IDLE: begin
          if (REQ_VALID) begin
            // Payload is captured once and then frozen until the next request,
            // which keeps AW/W stable for as long as their VALIDs are up.
            AW_ADDR  <= REQ_ADDR;
            W_DATA   <= REQ_DATA;
            W_STRB   <= REQ_STRB;
            AW_VALID <= 1'b1;
            W_VALID  <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            state    <= WM_SEND;
          end
        end

        WM_SEND: begin
          // AW and W complete independently, in either order or together.
          if (aw_hs) begin
            AW_VALID <= 1'b0;
            aw_done  <= 1'b1;
          end
          if (w_hs) begin
            W_VALID <= 1'b0;
            w_done  <= 1'b1;
          end
          // Include handshakes landing this cycle so the later one moves us
          // straight on without an extra idle cycle.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state <= WM_WAIT_B;
          end
        end

        WM_WAIT_B: begin
          if (B_VALID) begin
            DONE_RESP  <= B_RESP;
            DONE_VALID <= 1'b1;
            state      <= WM_DONE;
          end
        end

        WM_DONE: begin
          // DONE_RESP is left untouched so the LSU can still see the last
          // result after the handshake.
          if (DONE_READY) begin
            DONE_VALID <= 1'b0;
            state      <= WM_IDLE;
          end
        end

        default: state <= WM_IDLE;
      endcase
    end
  end

endmodule : axi4_lite_write_master

// File: tb/tb_axi4_lite_write_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_write_master
// Scenario tasks drive the LSU and slave sides cycle by cycle and compare the
// control outputs against per-cycle expectation tables. Expected AW/W payloads
// and B responses go into queues as stimulus is driven; a negedge monitor pops
// them at each AW, W and DONE handshake and also checks that a pending VALID
// and its payload stay put until accepted.
// -----------------------------------------------------------------------------
module tb_axi4_lite_write_master;
  import axi4_lite_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_DATA;
  logic [STRB_W-1:0] REQ_STRB;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              AW_VALID;
  logic              AW_READY;
  logic [DATA_W-1:0] W_DATA;
  logic [STRB_W-1:0] W_STRB;
  logic              W_VALID;
  logic              W_READY;
  logic [1:0]        B_RESP;
  logic              B_VALID;
  logic              B_READY;
  logic              DONE_VALID;
  logic [1:0]        DONE_RESP;
  logic              DONE_READY;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0]        aw_q[$];
  logic [DATA_W+STRB_W-1:0] w_q[$];
  logic [1:0]               resp_q[$];

  axi4_lite_write_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_DATA   (REQ_DATA),
    .REQ_STRB   (REQ_STRB),
    .AW_ADDR    (AW_ADDR),
    .AW_VALID   (AW_VALID),
    .AW_READY   (AW_READY),
    .W_DATA     (W_DATA),
    .W_STRB     (W_STRB),
    .W_VALID    (W_VALID),
    .W_READY    (W_READY),
    .B_RESP     (B_RESP),
    .B_VALID    (B_VALID),
    .B_READY    (B_READY),
    .DONE_VALID (DONE_VALID),
    .DONE_RESP  (DONE_RESP),
    .DONE_READY (DONE_READY)
  );

  always #5 CLK = ~CLK;

  // Control outputs packed as {REQ_READY, AW_VALID, W_VALID, B_READY, DONE_VALID}.
  function automatic logic [4:0] ctrl();
    return {REQ_READY, AW_VALID, W_VALID, B_READY, DONE_VALID};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [STRB_W-1:0] s);
    REQ_VALID = 1'b1;
    REQ_ADDR  = a;
    REQ_DATA  = d;
    REQ_STRB  = s;
    aw_q.push_back(a);
    w_q.push_back({d, s});
  endtask

  task automatic send_b(input logic [1:0] r);
    B_VALID = 1'b1;
    B_RESP  = r;
    resp_q.push_back(r);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: scoreboard pops at handshakes, plus VALID/payload stability.
  // ---------------------------------------------------------------------------
  logic                     prev_aw_wait = 1'b0;
  logic                     prev_w_wait  = 1'b0;
  logic [ADDR_W-1:0]        prev_addr;
  logic [DATA_W+STRB_W-1:0] prev_wd;

  always @(negedge CLK) begin
    logic [ADDR_W-1:0]        ea;
    logic [DATA_W+STRB_W-1:0] ew;
    logic [1:0]               er;
    if (!RST_N) begin
      prev_aw_wait = 1'b0;
      prev_w_wait  = 1'b0;
    end else begin
      if (prev_aw_wait) begin
        checks++;
        if (AW_VALID !== 1'b1 || AW_ADDR !== prev_addr) begin
          errors++;
          $display("FAIL aw_stable: AW_VALID=%0b AW_ADDR=%h, need 1 and %h", AW_VALID, AW_ADDR, prev_addr);
        end
      end
      if (prev_w_wait) begin
        checks++;
        if (W_VALID !== 1'b1 || {W_DATA, W_STRB} !== prev_wd) begin
          errors++;
          $display("FAIL w_stable: W_VALID=%0b W=%h, need 1 and %h", W_VALID, {W_DATA, W_STRB}, prev_wd);
        end
      end
      if (AW_VALID && AW_READY) begin
        checks++;
        if (aw_q.size() == 0) begin
          errors++;
          $display("FAIL aw_unexpected: AW handshake addr %h with nothing expected", AW_ADDR);
        end else begin
          ea = aw_q.pop_front();
          if (AW_ADDR !== ea) begin
            errors++;
            $display("FAIL aw_addr: got %h, expected %h", AW_ADDR, ea);
          end
        end
      end
      if (W_VALID && W_READY) begin
        checks++;
        if (w_q.size() == 0) begin
          errors++;
          $display("FAIL w_unexpected: W handshake %h with nothing expected", {W_DATA, W_STRB});
        end else begin
          ew = w_q.pop_front();
          if ({W_DATA, W_STRB} !== ew) begin
            errors++;
            $display("FAIL w_payload: got %h, expected %h", {W_DATA, W_STRB}, ew);
          end
        end
      end
      if (DONE_VALID && DONE_READY) begin
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: DONE handshake resp %b with nothing expected", DONE_RESP);
        end else begin
          er = resp_q.pop_front();
          if (DONE_RESP !== er) begin
            errors++;
            $display("FAIL done_resp: got %b, expected %b", DONE_RESP, er);
          end
        end
      end
      prev_aw_wait = AW_VALID && !AW_READY;
      prev_w_wait  = W_VALID && !W_READY;
      prev_addr    = AW_ADDR;
      prev_wd      = {W_DATA, W_STRB};
    end
  end

  // ---------------------------------------------------------------------------
  // Scenarios. Cycle 0 is the cycle the request is presented and accepted.
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tick();
    checks++;
    if (ctrl() !== 5'b10000 || DONE_RESP !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: ctrl=%b resp=%b, need 10000 and 00", ctrl(), DONE_RESP);
    end
    checks++;
    if (AW_ADDR !== '0 || W_DATA !== '0 || W_STRB !== '0) begin
      errors++;
      $display("FAIL reset_payload: AW_ADDR=%h W_DATA=%h W_STRB=%h, need all zero", AW_ADDR, W_DATA, W_STRB);
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [4:0] exp_c [5];
    exp_c = '{5'b10000, 5'b01100, 5'b00010, 5'b00001, 5'b10000};
    AW_READY = 1'b1; W_READY = 1'b1; DONE_READY = 1'b1;
    issue(64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) REQ_VALID = 1'b0;
      checks++;
      if (ctrl() !== exp_c[c]) begin
        errors++;
        $display("FAIL single_ctrl c%0d: ctrl=%b, expected %b", c, ctrl(), exp_c[c]);
      end
      if (c == 1) begin
        checks++;
        if (AW_ADDR !== 64'h8000_0010 || W_DATA !== 64'hDEAD_BEEF_0123_4567 || W_STRB !== 8'hFF) begin
          errors++;
          $display("FAIL single_payload: AW_ADDR=%h W_DATA=%h W_STRB=%h", AW_ADDR, W_DATA, W_STRB);
        end
      end
      if (c == 2) send_b(RESP_OKAY);
      if (c == 3) begin
        B_VALID = 1'b0;
        checks++;
        if (DONE_RESP !== 2'b00) begin
          errors++;
          $display("FAIL single_resp: DONE_RESP=%b, expected 00", DONE_RESP);
        end
      end
    end
  endtask

  task automatic test_aw_first();
    logic [4:0] exp_c [9];
    exp_c = '{5'b10000, 5'b01100, 5'b00100, 5'b00100, 5'b00100,
              5'b00100, 5'b00010, 5'b00001, 5'b10000};
    AW_READY = 1'b1; W_READY = 1'b0;
    issue(64'h0000_0000_1000_0040, 64'h1122_3344_5566_7788, 8'h0F);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) REQ_VALID = 1'b0;
      checks++;
      if (ctrl() !== exp_c[c]) begin
        errors++;
        $display("FAIL aw_first_ctrl c%0d: ctrl=%b, expected %b", c, ctrl(), exp_c[c]);
      end
      if (c == 5) W_READY = 1'b1;
      if (c == 6) send_b(RESP_EXOKAY);
      if (c == 7) B_VALID = 1'b0;
    end
  endtask

  task automatic test_w_first();
    logic [4:0] exp_c [8];
    exp_c = '{5'b10000, 5'b01100, 5'b01000, 5'b01000, 5'b01000,
              5'b00010, 5'b00001, 5'b10000};
    AW_READY = 1'b0; W_READY = 1'b1;
    issue(64'hFFFF_0000_0000_0008, 64'hCAFE_F00D_0000_0001, 8'hA5);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) REQ_VALID = 1'b0;
      checks++;
      if (ctrl() !== exp_c[c]) begin
        errors++;
        $display("FAIL w_first_ctrl c%0d: ctrl=%b, expected %b", c, ctrl(), exp_c[c]);
      end
      if (c == 4) AW_READY = 1'b1;
      if (c == 5) send_b(RESP_DECERR);
      if (c == 6) B_VALID = 1'b0;
    end
  endtask

  task automatic test_error_resp();
    logic [4:0] exp_c [8];
    exp_c = '{5'b10000, 5'b01100, 5'b00010, 5'b00001, 5'b00001,
              5'b00001, 5'b00001, 5'b10000};
    AW_READY = 1'b1; W_READY = 1'b1; DONE_READY = 1'b0;
    issue(64'h0000_0000_2000_0000, 64'h0, 8'h01);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) REQ_VALID = 1'b0;
      checks++;
      if (ctrl() !== exp_c[c]) begin
        errors++;
        $display("FAIL error_ctrl c%0d: ctrl=%b, expected %b", c, ctrl(), exp_c[c]);
      end
      if (c >= 3) begin
        checks++;
        if (DONE_RESP !== 2'b10) begin
          errors++;
          $display("FAIL error_resp c%0d: DONE_RESP=%b, expected 10", c, DONE_RESP);
        end
      end
      if (c == 2) send_b(RESP_SLVERR);
      if (c == 3) B_VALID = 1'b0;
      if (c == 6) DONE_READY = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]        exp_c [9];
    logic [ADDR_W-1:0] exp_a [9];
    logic [ADDR_W-1:0] a0, a1;
    a0 = 64'h0000_0000_3000_0100;
    a1 = 64'h0000_0000_3000_0200;
    exp_c = '{5'b10000, 5'b01100, 5'b00010, 5'b00001, 5'b10000,
              5'b01100, 5'b00010, 5'b00001, 5'b10000};
    exp_a = '{a0, a0, a0, a0, a0, a1, a1, a1, a1};
    AW_READY = 1'b1; W_READY = 1'b1; DONE_READY = 1'b1;
    // B_VALID stays up throughout; it must only be taken in WAIT_B.
    send_b(RESP_OKAY);
    resp_q.push_back(RESP_OKAY);
    issue(a0, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) issue(a1, 64'h5555_5555_5555_5555, 8'h3C);
      if (c == 5) REQ_VALID = 1'b0;
      checks++;
      if (ctrl() !== exp_c[c] || AW_ADDR !== exp_a[c]) begin
        errors++;
        $display("FAIL b2b c%0d: ctrl=%b AW_ADDR=%h, expected %b and %h", c, ctrl(), AW_ADDR, exp_c[c], exp_a[c]);
      end
    end
    B_VALID = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    AW_READY = 1'b0; W_READY = 1'b0; DONE_READY = 1'b1;
    issue(64'h0000_0000_4000_0000, 64'h1234, 8'hFF);
    tick();
    REQ_VALID = 1'b0;
    tick();
    checks++;
    if (ctrl() !== 5'b01100) begin
      errors++;
      $display("FAIL rst_mid_pre: ctrl=%b, expected 01100", ctrl());
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (ctrl() !== 5'b10000 || AW_ADDR !== '0 || DONE_RESP !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_async: ctrl=%b AW_ADDR=%h resp=%b, need 10000, 0, 00", ctrl(), AW_ADDR, DONE_RESP);
    end
    aw_q.delete();
    w_q.delete();
    resp_q.delete();
    tick();
    RST_N = 1'b1;
    AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; B_RESP = RESP_SLVERR;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (ctrl() !== 5'b10000) begin
        errors++;
        $display("FAIL rst_mid_after c%0d: ctrl=%b, expected 10000", c, ctrl());
      end
    end
    B_VALID = 1'b0;
  endtask

  initial begin
    REQ_VALID  = 1'b0;
    REQ_ADDR   = '0;
    REQ_DATA   = '0;
    REQ_STRB   = '0;
    AW_READY   = 1'b0;
    W_READY    = 1'b0;
    B_RESP     = 2'b00;
    B_VALID    = 1'b0;
    DONE_READY = 1'b0;

    test_reset();
    test_single();
    test_aw_first();
    test_w_first();
    test_error_resp();
    test_back_to_back();
    test_reset_mid_send();

    tick();
    checks++;
    if (aw_q.size() != 0 || w_q.size() != 0 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left aw=%0d w=%0d resp=%0d, expected 0 0 0", aw_q.size(), w_q.size(), resp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_axi4_lite_write_master
